dadda_mul_arbiter: RTL and testbench

//   Shares one combinational 16x16 dadda_multiplier instance among NUM_REQ

---
 rtl/dadda_mul_arbiter.sv | 152 +++++++++++++++
 tb/tb_dadda_mul_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_arbiter.sv
// Round-robin shared 16x16 Dadda multiplier: N requesters feed a two-stage
// operand/product pipeline that returns tagged products in acceptance order.

module dadda_multiplier (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] product
);

   // Row heights after each Dadda reduction stage, starting from 16 partial products.
   function automatic int stage_height(input int s);
      case (s)
         0:       return 13;
         1:       return 9;
         2:       return 6;
         3:       return 4;
         4:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic [31:0] dadda_product(input logic [15:0] op_a, input logic [15:0] op_b);
      logic [31:0] rows [16];
      logic [31:0] nxt  [16];
      logic [31:0] x, y, z;
      int n, k;
      for (int i = 0; i < 16; i++)
         rows[i] = op_b[i] ? ({16'd0, op_a} << i) : 32'd0;
      n = 16;
      for (int s = 0; s < 6; s++) begin
         // Only as many 3:2 compressors as needed to reach the next height.
         k = n - stage_height(s);
         for (int i = 0; i < 16; i++)
            nxt[i] = 32'd0;
         for (int i = 0; i < 5; i++) begin
            if (i < k) begin
               x = rows[4'(3*i)];
               y = rows[4'(3*i+1)];
               z = rows[4'(3*i+2)];
               nxt[4'(2*i)]   = x ^ y ^ z;
               nxt[4'(2*i+1)] = ((x & y) | (x & z) | (y & z)) << 1;
            end
         end
         for (int j = 0; j < 16; j++)
            if (j >= 3*k && j < n)
               nxt[4'(j-k)] = rows[j];
         rows = nxt;
         n = stage_height(s);
      end
      return rows[0] + rows[1];
   endfunction

   assign product = dadda_product(a, b);

endmodule

module dadda_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*16-1:0] req_a,
   input  logic [NUM_REQ*16-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_product,
   output logic                  busy
);

   logic            s1_v;
   logic [15:0]     s1_a;
   logic [15:0]     s1_b;
   logic [ID_W-1:0] s1_id;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] gnt;
   logic [ID_W-1:0] next_ptr;
   logic [ID_W:0]   probe;
   logic            gnt_found;
   logic            s2_free;
   logic            s1_free;
   logic            accept;
   logic [31:0]     mul_product;

   dadda_multiplier u_mul (
      .a       (s1_a),
      .b       (s1_b),
      .product (mul_product)
   );

   assign s2_free  = !rsp_valid | rsp_ready;
   assign s1_free  = !s1_v | s2_free;
   assign accept   = gnt_found & s1_free;
   assign next_ptr = (gnt == ID_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
   assign busy     = s1_v | rsp_valid;

   // Walk upward from rr_ptr with wrap; first pending requester wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      probe     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         probe = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (probe >= (ID_W+1)'(NUM_REQ))
            probe = probe - (ID_W+1)'(NUM_REQ);
         if (!gnt_found && req_valid[probe[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt       = probe[ID_W-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && accept)
         req_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v        <= 1'b0;
         s1_a        <= '0;
         s1_b        <= '0;
         s1_id       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_product <= '0;
         rr_ptr      <= '0;
      end else begin
         if (s2_free) begin
            rsp_valid <= s1_v;
            if (s1_v) begin
               rsp_product <= mul_product;
               rsp_id      <= s1_id;
            end
         end
         if (s1_free) begin
            s1_v <= accept;
            if (accept) begin
               s1_a   <= req_a[16*gnt +: 16];
               s1_b   <= req_b[16*gnt +: 16];
               s1_id  <= gnt;
               rr_ptr <= next_ptr;
            end
         end
      end
   end

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Scoreboard bench for dadda_mul_arbiter: a driver feeds directed vectors and
// queues expected tagged products, a monitor pops them as responses appear.

module tb_dadda_mul_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*16-1:0] req_a;
   logic [N*16-1:0] req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_product;
   logic          busy;

   dadda_mul_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {int port; logic [15:0] a; logic [15:0] b; logic [31:0] p;} vec_t;
   typedef struct {int id; logic [31:0] p; int at_edge; bit lat;} exp_t;

   vec_t pend[$];
   exp_t expq[$];
   int   glog_id[$];
   int   glog_edge[$];
   int   want_ids[$];
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_err    = 0;
   bit   lat_on;
   int   drv_k;
   int   drv_nacc;
   exp_t drv_e;
   exp_t mon_e;

   always @(posedge clk) edge_cnt++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   function automatic int find_pend(input int p);
      for (int i = 0; i < pend.size(); i++)
         if (pend[i].port == p) return i;
      return -1;
   endfunction

   task automatic push(input int port, input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
      vec_t v;
      v.port = port; v.a = a; v.b = b; v.p = p;
      pend.push_back(v);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((pend.size() != 0 || expq.size() != 0 || busy) && t < 200) begin
         tick(1);
         t++;
      end
      chk({name, "_drain_timeout"}, 64'(t >= 200), 0);
   endtask

   task automatic check_grants(input string name, input bit consec);
      chk({name, "_grant_count"}, glog_id.size(), want_ids.size());
      for (int i = 0; i < want_ids.size() && i < glog_id.size(); i++) begin
         chk({name, "_grant_id"}, glog_id[i], want_ids[i]);
         if (consec && i > 0)
            chk({name, "_grant_step"}, glog_edge[i] - glog_edge[i-1], 1);
      end
      glog_id.delete();
      glog_edge.delete();
      want_ids.delete();
   endtask

   // Driver: present pending vectors, record accepted ones into the scoreboard.
   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int p = 0; p < N; p++) begin
            drv_k = find_pend(p);
            if (drv_k >= 0) begin
               req_valid[p]       = 1'b1;
               req_a[16*p +: 16]  = pend[drv_k].a;
               req_b[16*p +: 16]  = pend[drv_k].b;
            end else begin
               req_valid[p] = 1'b0;
            end
         end
         @(negedge clk);
         drv_nacc = 0;
         for (int p = 0; p < N; p++) begin
            if (req_valid[p] && req_ready[p]) begin
               drv_k = find_pend(p);
               drv_nacc++;
               if (drv_k >= 0) begin
                  drv_e.id      = p;
                  drv_e.p       = pend[drv_k].p;
                  drv_e.at_edge = edge_cnt + 1;
                  drv_e.lat     = lat_on;
                  expq.push_back(drv_e);
                  glog_id.push_back(p);
                  glog_edge.push_back(edge_cnt + 1);
                  pend.delete(drv_k);
               end
            end
         end
         if (drv_nacc != 0)
            chk("ready_onehot", drv_nacc, 1);
      end
   end

   // Monitor: every response transfer pops and compares the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               mon_e = expq.pop_front();
               chk("rsp_id", rsp_id, mon_e.id);
               chk("rsp_product", rsp_product, mon_e.p);
               if (mon_e.lat)
                  chk("rsp_latency", edge_cnt + 1 - mon_e.at_edge, 2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      lat_on    = 1'b1;

      // Reset state, with a request already waiting.
      push(0, 16'h0003, 16'h0005, 32'h0000_000F);
      tick(3);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_product", rsp_product, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      // 1: single product from requester 0.
      wait_idle("t1");
      chk("t1_busy", busy, 0);
      want_ids = '{0};
      check_grants("t1", 1'b0);

      // 2: back-to-back from requester 2, including the max corner.
      push(2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
      push(2, 16'h8000, 16'h0002, 32'h0001_0000);
      wait_idle("t2");
      want_ids = '{2, 2};
      check_grants("t2", 1'b1);

      // 3: all four valid; rotation starts at 3 after test 2 and wraps.
      push(0, 16'h0002, 16'h0003, 32'h0000_0006);
      push(1, 16'h0007, 16'h0009, 32'h0000_003F);
      push(2, 16'h00FF, 16'h00FF, 32'h0000_FE01);
      push(3, 16'h000A, 16'h000A, 32'h0000_0064);
      push(0, 16'h0100, 16'h0100, 32'h0001_0000);
      push(1, 16'h1234, 16'h0010, 32'h0001_2340);
      push(2, 16'hFFFF, 16'h0001, 32'h0000_FFFF);
      push(3, 16'h8000, 16'h8000, 32'h4000_0000);
      wait_idle("t3");
      want_ids = '{3, 0, 1, 2, 3, 0, 1, 2};
      check_grants("t3", 1'b1);

      // 4: backpressure with a full pipeline.
      rsp_ready = 1'b0;
      lat_on    = 1'b0;
      push(1, 16'h0011, 16'h0011, 32'h0000_0121);
      push(1, 16'h0100, 16'h0003, 32'h0000_0300);
      push(1, 16'h0005, 16'h0005, 32'h0000_0019);
      tick(4);
      chk("t4_in_flight", expq.size(), 2);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t4_req_ready", req_ready, 0);
         chk("t4_rsp_valid", rsp_valid, 1);
         chk("t4_rsp_id", rsp_id, 1);
         chk("t4_rsp_product", rsp_product, 32'h0000_0121);
         chk("t4_busy", busy, 1);
      end
      rsp_ready = 1'b1;
      wait_idle("t4");
      want_ids = '{1, 1, 1};
      check_grants("t4", 1'b0);

      // 5: pointer at 3 with only requester 1 pending, then idle, then 1/2/3 together.
      lat_on = 1'b1;
      push(2, 16'h0004, 16'h0004, 32'h0000_0010);
      wait_idle("t5a");
      push(1, 16'h0006, 16'h0007, 32'h0000_002A);
      wait_idle("t5b");
      want_ids = '{2, 1};
      check_grants("t5a", 1'b0);
      tick(5);
      push(1, 16'h0003, 16'h0003, 32'h0000_0009);
      push(2, 16'h0010, 16'h0010, 32'h0000_0100);
      push(3, 16'h0020, 16'h0002, 32'h0000_0040);
      wait_idle("t5c");
      want_ids = '{2, 3, 1};
      check_grants("t5c", 1'b1);

      // 6: reset with both stages full flushes everything and restarts rotation at 0.
      rsp_ready = 1'b0;
      lat_on    = 1'b0;
      push(1, 16'h0009, 16'h0009, 32'h0000_0051);
      push(1, 16'h000B, 16'h000B, 32'h0000_0079);
      tick(4);
      chk("t6_pre_busy", busy, 1);
      chk("t6_pre_rsp_valid", rsp_valid, 1);
      chk("t6_pre_in_flight", expq.size(), 2);
      rst_n = 1'b0;
      #1;
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rsp_product", rsp_product, 0);
      chk("t6_req_ready", req_ready, 0);
      expq.delete();
      glog_id.delete();
      glog_edge.delete();
      rsp_ready = 1'b1;
      lat_on    = 1'b1;
      tick(2);
      rst_n = 1'b1;
      push(0, 16'h0002, 16'h0002, 32'h0000_0004);
      push(3, 16'h0003, 16'h0007, 32'h0000_0015);
      wait_idle("t6a");
      want_ids = '{0, 3};
      check_grants("t6a", 1'b1);
      push(3, 16'h1111, 16'h0003, 32'h0000_3333);
      wait_idle("t6b");
      want_ids = '{3};
      check_grants("t6b", 1'b0);

      chk("end_scoreboard_empty", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
